disp_rdarb: RTL and testbench

Two-port AXI read-channel arbiter that shares one AXI master read port (AR + R) between the display VRAM fetch path (port 0) and a second read requester (port 1, e.g. a capture or draw engine). It holds at most one burst outstanding. Ownership is round-robin, and port 0 gets priority while its line buffer is running low. The arbiter sits between the requesters' AR/R signals and the top-level M_AXI_AR*/M_AXI_R* pins, in the ACLK domain.

---
 rtl/disp_rdarb_if.sv | 26 ++
 rtl/disp_rdarb.sv | 150 +++++++++++++++
 tb/tb_disp_rdarb.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/disp_rdarb_if.sv
// AXI read-channel bundle (AR + R) shared by the requester ports and the master port of
// the display read arbiter. The master modport drives AR and RREADY; the slave modport
// answers with ARREADY and the R beat.
interface disp_rdarb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARADDR, ARLEN, ARVALID, RREADY,
    input  ARREADY, RDATA, RLAST, RVALID
  );

  modport slave (
    input  ARADDR, ARLEN, ARVALID, RREADY,
    output ARREADY, RDATA, RLAST, RVALID
  );
endinterface

// File: rtl/disp_rdarb.sv
// Two-port AXI read arbiter: shares one master AR/R port between the display VRAM fetch
// (port 0) and a second requester (port 1). One burst outstanding at a time, round-robin
// ownership, with port 0 taking every idle arbitration while S0_URGENT is high.
module disp_rdarb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic       ACLK,
  input  logic       ARST,
  disp_rdarb_if.slave  s0,
  disp_rdarb_if.slave  s1,
  disp_rdarb_if.master m,
  input  logic       S0_URGENT,
  output logic [1:0] GRANT,
  output logic       LEN_ERR
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;     // port granted most recently
  logic              owner_q, owner_d;   // port owning the current burst
  logic [7:0]        cnt_q, cnt_d;       // beats remaining after the current one
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic              arvalid_q, arvalid_d;
  logic [1:0]        grant_q, grant_d;
  logic              len_err_q, len_err_d;

  logic              req_any;
  logic              win;
  logic              in_idle;
  logic              in_data;
  logic              own_rready;
  logic              m_rready;
  logic              beat;
  logic [DATA_W-1:0] rdata;

  // Winner selection: urgent port 0 first, then a lone requester, then round-robin.
  always_comb begin
    req_any = s0.ARVALID | s1.ARVALID;
    win     = 1'b0;
    if (S0_URGENT && s0.ARVALID) begin
      win = 1'b0;
    end else if (s0.ARVALID && s1.ARVALID) begin
      win = ~last_q;
    end else begin
      win = s1.ARVALID;
    end
  end

  assign in_idle    = (state_q == StIdle);
  assign in_data    = (state_q == StData);
  assign own_rready = owner_q ? s1.RREADY : s0.RREADY;
  // Derived from the state register so it falls with the asynchronous reset.
  assign m_rready   = in_data & own_rready;
  assign beat       = m.RVALID & m_rready;
  assign rdata      = m.RDATA;

  assign s0.ARREADY = in_idle & req_any & ~win;
  assign s1.ARREADY = in_idle & req_any & win;

  assign m.ARADDR  = araddr_q;
  assign m.ARLEN   = arlen_q;
  assign m.ARVALID = arvalid_q;
  assign m.RREADY  = m_rready;

  assign s0.RDATA  = rdata;
  assign s1.RDATA  = rdata;
  assign s0.RVALID = in_data & ~owner_q & m.RVALID;
  assign s1.RVALID = in_data & owner_q & m.RVALID;
  assign s0.RLAST  = in_data & ~owner_q & m.RLAST;
  assign s1.RLAST  = in_data & owner_q & m.RLAST;

  assign GRANT   = grant_q;
  assign LEN_ERR = len_err_q;

  // Next-state logic: accept in IDLE, hold AR until handshake, count beats in DATA.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arvalid_d = arvalid_q;
    grant_d   = grant_q;
    len_err_d = len_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          araddr_d  = win ? s1.ARADDR : s0.ARADDR;
          arlen_d   = win ? s1.ARLEN : s0.ARLEN;
          cnt_d     = win ? s1.ARLEN : s0.ARLEN;
          owner_d   = win;
          grant_d   = win ? 2'b10 : 2'b01;
          arvalid_d = 1'b1;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        if (m.ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = StData;
        end
      end
      StData: begin
        if (beat) begin
          // Stop at zero on overlong bursts; the error is already latched by then.
          if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
          if (m.RLAST) begin
            if (cnt_q != 8'd0) len_err_d = 1'b1;
            last_d  = owner_q;
            grant_d = 2'b00;
            state_d = StIdle;
          end else if (cnt_q == 8'd0) begin
            len_err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      cnt_q     <= 8'd0;
      araddr_q  <= '0;
      arlen_q   <= 8'd0;
      arvalid_q <= 1'b0;
      grant_q   <= 2'b00;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arvalid_q <= arvalid_d;
      grant_q   <= grant_d;
      len_err_q <= len_err_d;
    end
  end

endmodule

// File: tb/tb_disp_rdarb.sv
// Directed bench for disp_rdarb: single burst with AR stall, round-robin, urgent priority,
// R backpressure, length mismatches and reset in the middle of a burst.
module tb_disp_rdarb;

  logic       ACLK = 1'b0;
  logic       ARST = 1'b1;
  logic       S0_URGENT;
  logic [1:0] GRANT;
  logic       LEN_ERR;

  int n_chk  = 0;
  int n_fail = 0;

  disp_rdarb_if #(.ADDR_W(32), .DATA_W(64)) s0_if ();
  disp_rdarb_if #(.ADDR_W(32), .DATA_W(64)) s1_if ();
  disp_rdarb_if #(.ADDR_W(32), .DATA_W(64)) m_if ();

  disp_rdarb #(.ADDR_W(32), .DATA_W(64)) dut (
    .ACLK      (ACLK),
    .ARST      (ARST),
    .s0        (s0_if),
    .s1        (s1_if),
    .m         (m_if),
    .S0_URGENT (S0_URGENT),
    .GRANT     (GRANT),
    .LEN_ERR   (LEN_ERR)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.ARADDR = '0; s0_if.ARLEN = '0; s0_if.ARVALID = 1'b0; s0_if.RREADY = 1'b0;
    s1_if.ARADDR = '0; s1_if.ARLEN = '0; s1_if.ARVALID = 1'b0; s1_if.RREADY = 1'b0;
    m_if.ARREADY = 1'b0; m_if.RDATA = '0; m_if.RLAST = 1'b0; m_if.RVALID = 1'b0;
    S0_URGENT = 1'b0;
  endtask

  task automatic do_reset();
    ARST = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    chk("rst_arvalid", 64'(m_if.ARVALID), 64'd0);
    chk("rst_araddr", 64'(m_if.ARADDR), 64'd0);
    chk("rst_arlen", 64'(m_if.ARLEN), 64'd0);
    chk("rst_grant", 64'(GRANT), 64'd0);
    chk("rst_len_err", 64'(LEN_ERR), 64'd0);
    chk("rst_rready", 64'(m_if.RREADY), 64'd0);
    chk("rst_rvalid", 64'({s0_if.RVALID, s1_if.RVALID, s0_if.RLAST, s1_if.RLAST}), 64'd0);
    ARST = 1'b0;
    cyc();
  endtask

  // Entered in IDLE with requests already driven; leaves in DATA at posedge+2.
  task automatic do_addr(input int own, input logic [31:0] addr, input logic [7:0] len,
                         input int wait_cyc, input bit hold);
    settle();
    chk("arready0", 64'(s0_if.ARREADY), 64'(own == 0));
    chk("arready1", 64'(s1_if.ARREADY), 64'(own == 1));
    cyc();
    if (!hold) begin
      if (own == 0) s0_if.ARVALID = 1'b0;
      else s1_if.ARVALID = 1'b0;
    end
    for (int i = 0; i <= wait_cyc; i++) begin
      m_if.ARREADY = (i == wait_cyc);
      settle();
      chk("m_arvalid", 64'(m_if.ARVALID), 64'd1);
      chk("m_araddr", 64'(m_if.ARADDR), 64'(addr));
      chk("m_arlen", 64'(m_if.ARLEN), 64'(len));
      chk("grant_addr", 64'(GRANT), (own == 1) ? 64'd2 : 64'd1);
      chk("arready_busy", 64'({s0_if.ARREADY, s1_if.ARREADY}), 64'd0);
      cyc();
    end
    m_if.ARREADY = 1'b0;
    settle();
    chk("m_arvalid_drop", 64'(m_if.ARVALID), 64'd0);
  endtask

  // Delivers nbeats with RLAST on beat last_idx; the non-owner always offers RREADY=1.
  task automatic do_data(input int own, input int nbeats, input int last_idx,
                         input bit toggle, input bit exp_err);
    int  b = 0;
    int  c = 0;
    logic rr;
    while (b < nbeats) begin
      rr = toggle ? logic'(c % 2 == 0) : 1'b1;
      if (own == 0) begin s0_if.RREADY = rr; s1_if.RREADY = 1'b1; end
      else begin s1_if.RREADY = rr; s0_if.RREADY = 1'b1; end
      m_if.RVALID = 1'b1;
      m_if.RDATA  = 64'(b);
      m_if.RLAST  = (b == last_idx);
      settle();
      chk("m_rready", 64'(m_if.RREADY), 64'(rr));
      chk("grant_data", 64'(GRANT), (own == 1) ? 64'd2 : 64'd1);
      if (own == 0) begin
        chk("own_rvalid", 64'(s0_if.RVALID), 64'd1);
        chk("own_rlast", 64'(s0_if.RLAST), 64'(b == last_idx));
        chk("own_rdata", s0_if.RDATA, 64'(b));
        chk("other_r", 64'({s1_if.RVALID, s1_if.RLAST}), 64'd0);
      end else begin
        chk("own_rvalid", 64'(s1_if.RVALID), 64'd1);
        chk("own_rlast", 64'(s1_if.RLAST), 64'(b == last_idx));
        chk("own_rdata", s1_if.RDATA, 64'(b));
        chk("other_r", 64'({s0_if.RVALID, s0_if.RLAST}), 64'd0);
      end
      if (rr) b++;
      c++;
      cyc();
    end
    m_if.RVALID = 1'b0; m_if.RLAST = 1'b0;
    s0_if.RREADY = 1'b0; s1_if.RREADY = 1'b0;
    settle();
    chk("grant_idle", 64'(GRANT), 64'd0);
    chk("rready_idle", 64'(m_if.RREADY), 64'd0);
    chk("len_err", 64'(LEN_ERR), 64'(exp_err));
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // Single port 0 burst, AR stalled 3 cycles, 16 beats.
    s0_if.ARADDR = 32'h1000_0000; s0_if.ARLEN = 8'd15; s0_if.ARVALID = 1'b1;
    do_addr(0, 32'h1000_0000, 8'd15, 3, 1'b0);
    do_data(0, 16, 15, 1'b0, 1'b0);
    // Stray beat while idle is not accepted or forwarded.
    m_if.RVALID = 1'b1; s0_if.RREADY = 1'b1;
    settle();
    chk("idle_rready", 64'(m_if.RREADY), 64'd0);
    chk("idle_rvalid", 64'({s0_if.RVALID, s1_if.RVALID}), 64'd0);
    m_if.RVALID = 1'b0; s0_if.RREADY = 1'b0;
    cyc();

    // Round-robin from reset: 0,1,0,1, next AR two cycles after each RLAST beat.
    do_reset();
    s0_if.ARADDR = 32'h0000_0100; s0_if.ARLEN = 8'd3; s0_if.ARVALID = 1'b1;
    s1_if.ARADDR = 32'h0000_0200; s1_if.ARLEN = 8'd3; s1_if.ARVALID = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_addr(k % 2, (k % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100, 8'd3, 0, 1'b1);
      do_data(k % 2, 4, 3, 1'b0, 1'b0);
    end

    // Urgent never pre-empts port 1, then wins twice against a requesting port 1.
    s0_if.ARVALID = 1'b0;
    do_addr(1, 32'h0000_0200, 8'd3, 0, 1'b1);
    S0_URGENT = 1'b1; s0_if.ARVALID = 1'b1;
    do_data(1, 4, 3, 1'b0, 1'b0);
    do_addr(0, 32'h0000_0100, 8'd3, 0, 1'b1);
    do_data(0, 4, 3, 1'b0, 1'b0);
    do_addr(0, 32'h0000_0100, 8'd3, 0, 1'b1);
    do_data(0, 4, 3, 1'b0, 1'b0);
    S0_URGENT = 1'b0; s0_if.ARVALID = 1'b0;
    do_addr(1, 32'h0000_0200, 8'd3, 0, 1'b0);
    do_data(1, 4, 3, 1'b0, 1'b0);

    // R backpressure: 8 beats, owner RREADY toggling.
    s0_if.ARADDR = 32'h0000_0800; s0_if.ARLEN = 8'd7; s0_if.ARVALID = 1'b1;
    do_addr(0, 32'h0000_0800, 8'd7, 1, 1'b0);
    do_data(0, 8, 7, 1'b1, 1'b0);

    // Early RLAST: ARLEN=3, RLAST on beat 2.
    s1_if.ARADDR = 32'h0000_0400; s1_if.ARLEN = 8'd3; s1_if.ARVALID = 1'b1;
    do_addr(1, 32'h0000_0400, 8'd3, 0, 1'b0);
    do_data(1, 2, 1, 1'b0, 1'b1);

    // Late RLAST after a fresh reset: ARLEN=1, RLAST on beat 4.
    do_reset();
    s0_if.ARADDR = 32'h0000_0500; s0_if.ARLEN = 8'd1; s0_if.ARVALID = 1'b1;
    do_addr(0, 32'h0000_0500, 8'd1, 0, 1'b0);
    do_data(0, 4, 3, 1'b0, 1'b1);

    // Reset after 5 of 16 beats, then a normal port 1 burst.
    do_reset();
    s0_if.ARADDR = 32'h0000_0600; s0_if.ARLEN = 8'd15; s0_if.ARVALID = 1'b1;
    do_addr(0, 32'h0000_0600, 8'd15, 0, 1'b0);
    m_if.RVALID = 1'b1; s0_if.RREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m_if.RDATA = 64'(i);
      cyc();
    end
    settle();
    chk("mid_rready", 64'(m_if.RREADY), 64'd1);
    ARST = 1'b1;
    #1;
    chk("arst_rready", 64'(m_if.RREADY), 64'd0);
    chk("arst_grant", 64'(GRANT), 64'd0);
    chk("arst_rvalid", 64'(s0_if.RVALID), 64'd0);
    chk("arst_arvalid", 64'(m_if.ARVALID), 64'd0);
    clear_inputs();
    cyc();
    ARST = 1'b0;
    cyc();
    s1_if.ARADDR = 32'h0000_0700; s1_if.ARLEN = 8'd3; s1_if.ARVALID = 1'b1;
    do_addr(1, 32'h0000_0700, 8'd3, 0, 1'b0);
    do_data(1, 4, 3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
